count_sample_fifo: RTL
======================

Name: count_sample_fifo

Overview:
Downstream capture stage for the gated photon counter.
- On each end-of-gate strobe from the counter, latches the held per-shot count into a circular buffer.
- Presents buffered counts as a valid/ready stream to the PS readout / FNN input path.
- Marks batch boundaries and flags overflow so that no shot is lost silently.

Parameters:
WIDTH, 8, count word width; matches the counter's COUNTER width.
ADDR_W, 4, buffer address width; depth = 2**ADDR_W entries.
BATCH, 100, samples per batch; M_LAST marks every BATCH-th word read (BATCH >= 1).

Ports:
CLK  input  1  clock.
RST_N  input  1  asynchronous active-low reset.
CLEAR_IN  input  1  one-cycle end-of-gate strobe from the counter; COUNT_IN is valid and held while it is high.
COUNT_IN  input  WIDTH  per-shot photon count.
FLUSH  input  1  synchronous flush: empties the buffer and resets the batch count.
THRESH  input  WIDTH  bright/dark threshold; used only with COUNT_THRESH_EN.
M_VALID  output  1  buffer non-empty.
M_READY  input  1  consumer accepts the word.
M_DATA  output  WIDTH  count at the head of the buffer.
M_STATE  output  1  discrimination bit of the head entry.
M_LAST  output  1  head word is the last word of a batch.
LEVEL  output  ADDR_W+1  current occupancy, 0..2**ADDR_W.
OVERFLOW  output  1  sticky: a capture was dropped.
OVF_CLR  input  1  synchronous clear of OVERFLOW.

Behaviour:
Reset (RST_N low, asynchronous):
- Pointers, LEVEL, batch counter and OVERFLOW go to 0; M_VALID = 0, M_LAST = 0.
- M_DATA/M_STATE are don't-care while M_VALID = 0; the bench must drive them 0 after reset.
- Buffer contents are not cleared.
- Reset mid-operation discards all entries.

Pointers and occupancy:
- wr_ptr and rd_ptr are ADDR_W+1 bits wide; full and empty are distinguished by the MSB.
- Pointers wrap modulo 2**(ADDR_W+1).
- LEVEL = wr_ptr - rd_ptr, registered.

Write and read:
- Write: CLEAR_IN = 1 and (not full, or a read accepted the same cycle) -> mem[wr_ptr] <= {state_bit, COUNT_IN}, wr_ptr + 1.
- Read: M_VALID & M_READY -> rd_ptr + 1.
- Output is first-word fall-through: M_DATA/M_STATE = mem[rd_ptr], read combinationally from the register array.
- M_VALID = !empty.
- Latency: CLEAR_IN high in cycle N into an empty buffer -> M_VALID = 1 and M_DATA = count in cycle N+1.

Boundary conditions:
- Full + CLEAR_IN + accepted read: both happen; LEVEL stays at 2**ADDR_W; no overflow.
- Full + CLEAR_IN, no read: word dropped, OVERFLOW <= 1, pointers unchanged.
- Empty + CLEAR_IN + M_READY: write only, since M_VALID was 0.
- Simultaneous write and read, not full: LEVEL unchanged.
- OVF_CLR and a new drop in the same cycle: OVERFLOW stays 1 (set wins).

Batch counter:
- Counts accepted reads 0..BATCH-1.
- M_LAST = M_VALID & (batch_cnt == BATCH-1).
- Wraps to 0 on the accepted read where M_LAST = 1.

FLUSH:
- Sets rd_ptr <= wr_ptr and batch_cnt <= 0; OVERFLOW is unaffected.
- Has priority over a read in the same cycle.
- CLEAR_IN in the same cycle is also discarded.

Optional Feature:
COUNT_THRESH_EN:
- Defined: at capture, state_bit = (COUNT_IN >= THRESH), unsigned compare; it is stored with the word and appears as M_STATE at the head.
- Undefined: state_bit = 0, M_STATE tied 0, THRESH ignored. The comparator and the extra storage bit are removed from the buffer.

Test Plan:
1. Single capture: after reset, pulse CLEAR_IN with COUNT_IN = 8'd23, M_READY = 0 -> next cycle M_VALID = 1, M_DATA = 23, LEVEL = 1. Then M_READY = 1 for one cycle -> M_VALID = 0, LEVEL = 0.
2. Fill and overflow (ADDR_W = 4): 17 strobes with counts 1..17, M_READY = 0 -> LEVEL = 16, OVERFLOW = 1. Drain reads 1..16 in order; 17 is absent. OVF_CLR -> OVERFLOW = 0.
3. Full with concurrent read: at LEVEL = 16, CLEAR_IN (count 99) together with M_READY -> LEVEL stays 16, OVERFLOW = 0, and 99 emerges 16th.
4. Batch marking (BATCH = 3): 7 captures, continuous M_READY -> M_LAST high on the 3rd and 6th words only.
5. Threshold (COUNT_THRESH_EN, THRESH = 5): counts 4, 5, 200 -> M_STATE = 0, 1, 1. Without the macro -> M_STATE = 0, 0, 0.
6. Flush and reset mid-stream: with LEVEL = 5, FLUSH together with CLEAR_IN -> LEVEL = 0, M_VALID = 0. Refill 3 words, then assert RST_N low mid-cycle -> all outputs 0 immediately.

Source files
------------

// File: rtl/count_sample_fifo.sv
// count_sample_fifo: capture buffer behind the gated photon counter.
// Each end-of-gate strobe writes the held count into a circular buffer.
// The buffer drains as a first-word-fall-through valid/ready stream.
// M_LAST marks every BATCH-th word read, and OVERFLOW sticks on a dropped capture.
// Optional macro COUNT_THRESH_EN stores a bright/dark bit (COUNT_IN >= THRESH)
// with each word and presents it as M_STATE.
module count_sample_fifo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned BATCH  = 100
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLEAR_IN,
  input  logic [WIDTH-1:0]  COUNT_IN,
  input  logic              FLUSH,
  input  logic [WIDTH-1:0]  THRESH,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic [WIDTH-1:0]  M_DATA,
  output logic              M_STATE,
  output logic              M_LAST,
  output logic [ADDR_W:0]   LEVEL,
  output logic              OVERFLOW,
  input  logic              OVF_CLR
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned BCNT_W = $clog2(BATCH + 1);
`ifdef COUNT_THRESH_EN
  localparam int unsigned ENTRY_W = WIDTH + 1;
`else
  localparam int unsigned ENTRY_W = WIDTH;
`endif

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W-1:0]   wr_ptr_nxt, rd_ptr_nxt;
  logic [BCNT_W-1:0]  batch_cnt;
  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] head;
  logic               empty, full, wr_en, rd_en, drop, batch_end;

  // Occupancy flags; the pointer MSB separates full from empty
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

`ifdef COUNT_THRESH_EN
  assign entry_in = {(COUNT_IN >= THRESH), COUNT_IN};
`else
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
  assign entry_in      = COUNT_IN;
`endif

  // Handshake decode; flush discards both the read and the capture of its cycle
  always_comb begin
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    drop       = 1'b0;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (FLUSH) begin
      rd_ptr_nxt = wr_ptr;
    end else begin
      rd_en = !empty && M_READY;
      wr_en = CLEAR_IN && (!full || rd_en);
      drop  = CLEAR_IN && full && !rd_en;
      if (rd_en) rd_ptr_nxt = rd_ptr + PTR_W'(1);
      if (wr_en) wr_ptr_nxt = wr_ptr + PTR_W'(1);
    end
  end

  assign batch_end = (batch_cnt == BCNT_W'(BATCH - 1));

  // Pointer, occupancy, batch and overflow state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      LEVEL     <= '0;
      batch_cnt <= '0;
      OVERFLOW  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      LEVEL  <= wr_ptr_nxt - rd_ptr_nxt;
      if (FLUSH)
        batch_cnt <= '0;
      else if (rd_en)
        batch_cnt <= batch_end ? '0 : batch_cnt + BCNT_W'(1);
      if (drop)
        OVERFLOW <= 1'b1;
      else if (OVF_CLR)
        OVERFLOW <= 1'b0;
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= entry_in;
  end

  // Fall-through head; outputs forced to zero while the buffer is empty
  assign head    = mem[rd_ptr[ADDR_W-1:0]];
  assign M_VALID = !empty;
  assign M_DATA  = M_VALID ? head[WIDTH-1:0] : '0;
  assign M_LAST  = M_VALID && batch_end;
`ifdef COUNT_THRESH_EN
  assign M_STATE = M_VALID && head[WIDTH];
`else
  assign M_STATE = 1'b0;
`endif

endmodule
